// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared multiply/divide op codes and sizing helper for the E-stage MDU.
package e_mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit holding HI/LO; results are computed at start
// and committed when the latency counter expires.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] md_out
);

    localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

    logic [31:0]   r_hi, r_lo, r_res_hi, r_res_lo;
    logic [CW-1:0] r_cnt;
    logic          w_sgn, w_mul, w_div;
    logic [31:0]   w_ua, w_ub, w_bd, w_q, w_r, w_quo, w_rem;
    logic [63:0]   w_prod;

    assign w_sgn = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign w_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign w_div = (md_op == MD_DIV) || (md_op == MD_DIVU);

    // Sign-extending for signed ops makes the low 64 bits of the product exact.
    assign w_prod = {{32{w_sgn & src_a[31]}}, src_a} * {{32{w_sgn & src_b[31]}}, src_b};

    // Divide magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    assign w_ua  = (w_sgn && src_a[31]) ? -src_a : src_a;
    assign w_ub  = (w_sgn && src_b[31]) ? -src_b : src_b;
    assign w_bd  = (src_b == '0) ? 32'd1 : w_ub;
    assign w_q   = w_ua / w_bd;
    assign w_r   = w_ua % w_bd;
    assign w_quo = (w_sgn && (src_a[31] ^ src_b[31])) ? -w_q : w_q;
    assign w_rem = (w_sgn && src_a[31]) ? -w_r : w_r;

    assign busy   = (r_cnt != '0);
    assign md_out = hilo_sel ? r_hi : r_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_cnt    <= '0;
        end else if (busy) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
        end else if (start) begin
            if (w_mul) begin
                {r_res_hi, r_res_lo} <= w_prod;
                r_cnt                <= CW'(MULT_CYCLES);
            end else if (w_div) begin
                // HI/LO cannot change while busy, so a zero divisor just recommits them.
                r_res_hi <= (src_b == '0) ? r_hi : w_rem;
                r_res_lo <= (src_b == '0) ? r_lo : w_quo;
                r_cnt    <= CW'(DIV_CYCLES);
            end else if (md_op == MD_MTHI) begin
                r_hi <= src_a;
            end else if (md_op == MD_MTLO) begin
                r_lo <= src_a;
            end
        end
    end

endmodule
